decode_issue: RTL
=================

Name: decode_issue

Overview:
- Parametrised decode/issue stage between fetch and EX, with a valid/ready handshake on both sides.
- Contains the architectural register file and a per-register pending-write scoreboard that allows several writers in flight.
- On a hazard it holds the instruction (backpressure) instead of dropping it, and it supports a pipeline flush.
- Consumes the fields produced by the existing `decoder` module; registers outputs on posedge clk.

Parameters:
- XLEN, 32, data/pc width.
- NREG, 32, number of architectural registers (x0 hardwired zero).
- RA_W, 5, register address width, $clog2(NREG).
- MAX_INFLIGHT, 3, maximum outstanding writes per register; pending counter width $clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock, all state on posedge.
- rstd  in  1  synchronous active-high reset.
- in_valid  in  1  fetch/decoder presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction pc.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RA_W each  decoded register addresses.
- in_imm  in  XLEN  decoded immediate.
- in_alu_code  in  6  ALU code.
- in_op1_type, in_op2_type  in  2 each  operand types (`OP_TYPE_*).
- in_w_enable, in_is_load, in_is_store, in_is_halt  in  1 each  decoded flags.
- flush  in  1  kill the held output and reject input this cycle.
- wb_enable  in  1  WB write strobe.
- wb_addr  in  RA_W  WB destination.
- wb_data  in  XLEN  WB data.
- out_valid  out  1  DE_* fields valid.
- out_ready  in  1  EX accepts.
- DE_pc, DE_rs1_data, DE_rs2_data, DE_imm  out  XLEN each  issued operands.
- DE_rd_addr  out  RA_W  issued destination.
- DE_alu_code  out  6  issued ALU code.
- DE_alu_op1_type, DE_alu_op2_type  out  2 each  issued operand types.
- DE_w_enable, DE_is_load, DE_is_store, DE_is_halt  out  1 each  issued flags.

Behaviour:
- Reset (rstd=1 at posedge):
  - out_valid=0; all DE_* cleared: data fields 0, DE_alu_code=`ALU_NOP, op types=`OP_TYPE_NONE, flags 0.
  - Register file and all pending counters cleared.
  - WB writes in the reset cycle are ignored.
  - in_ready=0 while rstd=1.
- Operand use:
  - use1 = (in_op1_type==`OP_TYPE_REG).
  - use2 = (in_op2_type==`OP_TYPE_REG) || in_is_store.
- busy(r) = r!=0 && (pend[r]!=0 || (out_valid && DE_w_enable && DE_rd_addr==r)).
- hazard conditions (any one suffices):
  - use1 && busy(rs1);
  - use2 && busy(rs2);
  - in_w_enable && rd!=0 && pend[rd]==MAX_INFLIGHT.
- in_ready = !rstd && !flush && !hazard && (!out_valid || out_ready). Combinational; must not depend on in_valid.
- Accept (in_valid && in_ready):
  - Output register loads all fields next posedge; out_valid=1.
  - rs data read from the register file; x0 always reads 0.
  - Latency 1 cycle when no hazard.
- Hold: out_valid && !out_ready keeps all DE_* stable.
- Drain: out_valid && out_ready with no accept → out_valid=0; DE_* keep their last value.
- Scoreboard:
  - pend[DE_rd_addr]++ on issue (out_valid && out_ready && DE_w_enable && DE_rd_addr!=0).
  - pend[wb_addr]-- on wb_enable && wb_addr!=0.
  - Same register, same cycle: net unchanged.
  - Decrement at 0 is an error: counter holds at 0, assertion fires.
  - Increment beyond MAX_INFLIGHT cannot occur (blocked by hazard).
- Register file: written at posedge on wb_enable && wb_addr!=0. Without bypass, a read in the same cycle returns the old value.
- Flush:
  - out_valid→0 next cycle; no scoreboard change, since the killed instruction was never counted.
  - flush && out_ready in the same cycle: flush wins, no issue.
  - WB processing continues during flush.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a WB write to register r in the same cycle is visible to decode in that cycle.
  - Read data for r is wb_data.
  - busy(r) treats pend[r]==1 with a matching WB as not pending.
  - The dependent instruction issues in the WB cycle.
- Undefined: the dependent instruction is accepted one cycle after the WB write.

Test Plan:
- Reset, then accept addi x1 (rd=1, imm=5, op2=IMM), out_ready=1 → out_valid=1 one cycle later with DE_rd_addr=1, DE_imm=5; pend[1]=1 after issue.
- add x2,x1,x1 following x1 writer → in_ready=0 until WB x1=0x1234. Then DE_rs1_data=DE_rs2_data=0x1234, issued in the WB cycle if bypass is defined, else the next cycle.
- Store with op2 type IMM and pending rs2=3 → stalls until WB x3; load with the same pending rs2 and op2 IMM → issues immediately.
- out_ready=0 for 4 cycles with out_valid=1 → DE_* unchanged and in_ready=0; then out_ready=1 → next instruction issued after 1 cycle.
- Three writers to x4 issued, no WB → fourth x4 writer stalls (MAX_INFLIGHT=3); one WB to x4 → accepted. Simultaneous issue to x4 and WB to x4 leaves pend[4] unchanged.
- flush with out_valid=1 holding an x5 writer → out_valid=0, pend[5]=0. Then rstd=1 mid-stream with pend≠0 → all counters 0, out_valid=0, reads of x1 return 0.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage holding the register file and a multi-writer pending scoreboard.
// Latency: one cycle from accept (in_valid && in_ready) to out_valid; outputs are registered.
// Backpressure: in_ready drops on RAW hazard, full pending counter, flush, reset or a held output.
// Optional: define DECODE_WB_BYPASS_EN to make a same-cycle WB write visible to decode.

`ifndef ALU_NOP
`define ALU_NOP 6'd0
`endif
`ifndef OP_TYPE_NONE
`define OP_TYPE_NONE 2'd0
`endif
`ifndef OP_TYPE_REG
`define OP_TYPE_REG 2'd1
`endif

module decode_issue #(
   parameter int XLEN         = 32,
   parameter int NREG         = 32,
   parameter int RA_W         = $clog2(NREG),
   parameter int MAX_INFLIGHT = 3
) (
   input  logic            clk,
   input  logic            rstd,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [RA_W-1:0] in_rs1_addr,
   input  logic [RA_W-1:0] in_rs2_addr,
   input  logic [RA_W-1:0] in_rd_addr,
   input  logic [XLEN-1:0] in_imm,
   input  logic [5:0]      in_alu_code,
   input  logic [1:0]      in_op1_type,
   input  logic [1:0]      in_op2_type,
   input  logic            in_w_enable,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic            in_is_halt,
   input  logic            flush,
   input  logic            wb_enable,
   input  logic [RA_W-1:0] wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] DE_pc,
   output logic [XLEN-1:0] DE_rs1_data,
   output logic [XLEN-1:0] DE_rs2_data,
   output logic [XLEN-1:0] DE_imm,
   output logic [RA_W-1:0] DE_rd_addr,
   output logic [5:0]      DE_alu_code,
   output logic [1:0]      DE_alu_op1_type,
   output logic [1:0]      DE_alu_op2_type,
   output logic            DE_w_enable,
   output logic            DE_is_load,
   output logic            DE_is_store,
   output logic            DE_is_halt
);

   localparam int            PW        = $clog2(MAX_INFLIGHT + 1);
   localparam logic [PW-1:0] PEND_ONE  = PW'(1);
   localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_INFLIGHT);
   localparam logic [PW-1:0] PEND_NEAR = PW'(MAX_INFLIGHT - 1);

   logic [XLEN-1:0] r_rf   [NREG];
   logic [PW-1:0]   r_pend [NREG];

   logic            w_use1, w_use2, w_wb_wr, w_accept, w_issue, w_inc;
   logic            w_de_wr1, w_de_wr2, w_de_wrd;
   logic            w_pend1, w_pend2, w_busy1, w_busy2, w_full, w_hazard;
   logic [XLEN-1:0] w_rs1_data, w_rs2_data;

   assign w_use1  = (in_op1_type == `OP_TYPE_REG);
   assign w_use2  = (in_op2_type == `OP_TYPE_REG) || in_is_store;
   assign w_wb_wr = wb_enable && (wb_addr != '0) && !rstd;

   // A writer parked in the output register is not yet counted in r_pend but still owns its rd.
   assign w_de_wr1 = out_valid && DE_w_enable && (DE_rd_addr == in_rs1_addr);
   assign w_de_wr2 = out_valid && DE_w_enable && (DE_rd_addr == in_rs2_addr);
   assign w_de_wrd = out_valid && DE_w_enable && (DE_rd_addr == in_rd_addr);

`ifdef DECODE_WB_BYPASS_EN
   // The last outstanding write retiring this cycle no longer blocks a reader.
   assign w_pend1 = (r_pend[in_rs1_addr] != '0) &&
                    !((r_pend[in_rs1_addr] == PEND_ONE) && w_wb_wr && (wb_addr == in_rs1_addr));
   assign w_pend2 = (r_pend[in_rs2_addr] != '0) &&
                    !((r_pend[in_rs2_addr] == PEND_ONE) && w_wb_wr && (wb_addr == in_rs2_addr));
   assign w_rs1_data = (in_rs1_addr == '0) ? '0 :
                       (w_wb_wr && (wb_addr == in_rs1_addr)) ? wb_data : r_rf[in_rs1_addr];
   assign w_rs2_data = (in_rs2_addr == '0) ? '0 :
                       (w_wb_wr && (wb_addr == in_rs2_addr)) ? wb_data : r_rf[in_rs2_addr];
`else
   assign w_pend1    = (r_pend[in_rs1_addr] != '0);
   assign w_pend2    = (r_pend[in_rs2_addr] != '0);
   assign w_rs1_data = (in_rs1_addr == '0) ? '0 : r_rf[in_rs1_addr];
   assign w_rs2_data = (in_rs2_addr == '0) ? '0 : r_rf[in_rs2_addr];
`endif

   assign w_busy1 = (in_rs1_addr != '0) && (w_pend1 || w_de_wr1);
   assign w_busy2 = (in_rs2_addr != '0) && (w_pend2 || w_de_wr2);

   // Count the parked writer too, so its later issue can never push the counter past the limit.
   assign w_full = in_w_enable && (in_rd_addr != '0) &&
                   ((r_pend[in_rd_addr] == PEND_MAX) ||
                    ((r_pend[in_rd_addr] == PEND_NEAR) && w_de_wrd));

   assign w_hazard = (w_use1 && w_busy1) || (w_use2 && w_busy2) || w_full;
   assign in_ready = !rstd && !flush && !w_hazard && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_issue  = out_valid && out_ready && !flush;
   assign w_inc    = w_issue && DE_w_enable && (DE_rd_addr != '0);

   // Output register: load on accept, hold under backpressure, clear valid on drain or flush.
   always_ff @(posedge clk) begin
      if (rstd) begin
         out_valid       <= 1'b0;
         DE_pc           <= '0;
         DE_rs1_data     <= '0;
         DE_rs2_data     <= '0;
         DE_imm          <= '0;
         DE_rd_addr      <= '0;
         DE_alu_code     <= `ALU_NOP;
         DE_alu_op1_type <= `OP_TYPE_NONE;
         DE_alu_op2_type <= `OP_TYPE_NONE;
         DE_w_enable     <= 1'b0;
         DE_is_load      <= 1'b0;
         DE_is_store     <= 1'b0;
         DE_is_halt      <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (w_accept) begin
         out_valid       <= 1'b1;
         DE_pc           <= in_pc;
         DE_rs1_data     <= w_rs1_data;
         DE_rs2_data     <= w_rs2_data;
         DE_imm          <= in_imm;
         DE_rd_addr      <= in_rd_addr;
         DE_alu_code     <= in_alu_code;
         DE_alu_op1_type <= in_op1_type;
         DE_alu_op2_type <= in_op2_type;
         DE_w_enable     <= in_w_enable;
         DE_is_load      <= in_is_load;
         DE_is_store     <= in_is_store;
         DE_is_halt      <= in_is_halt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Register file: WB writes land at the clock edge; x0 is never written.
   always_ff @(posedge clk) begin
      if (rstd) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (w_wb_wr) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   // Pending-write counters: +1 on issue of a writer, -1 on its WB, unchanged when both coincide.
   always_ff @(posedge clk) begin
      if (rstd) begin
         for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (w_inc && (DE_rd_addr == RA_W'(i)) && !(w_wb_wr && (wb_addr == RA_W'(i))))
               r_pend[i] <= r_pend[i] + PEND_ONE;
            else if (w_wb_wr && (wb_addr == RA_W'(i)) && !(w_inc && (DE_rd_addr == RA_W'(i))) &&
                     (r_pend[i] != '0))
               r_pend[i] <= r_pend[i] - PEND_ONE;
         end
      end
   end

   // A writeback must always retire a write that was previously issued.
   a_wb_underflow: assert property (@(posedge clk) disable iff (rstd)
      !(w_wb_wr && (r_pend[wb_addr] == '0) && !(w_inc && (DE_rd_addr == wb_addr))));

endmodule
